// File: rtl/spmv_pkg.sv
// Shared types for the streaming SpMV row PE: FSM states, pipeline depth and the
// saturating adder used when SPMV_SAT_EN is defined.
package spmv_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    // Element pipeline: RAM read, multiply, accumulate.
    localparam int PIPE_DEPTH = 3;

    // Signed add clamped to a w-bit two's complement range (w <= 63).
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int w);
        logic signed [64:0] s, mx, mn;
        s  = {a[63], a} + {b[63], b};
        mx = (65'sd1 <<< (w - 1)) - 65'sd1;
        mn = -(65'sd1 <<< (w - 1));
        if (s > mx) return mx[63:0];
        if (s < mn) return mn[63:0];
        return s[63:0];
    endfunction

endpackage

// File: rtl/spmv_row_pe_res_fifo.sv
// Result FIFO for spmv_row_pe: synchronous, any depth >= 2, head shown
// combinationally (zero when empty), occupancy count for backpressure.
module spmv_res_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_pop,
    output logic [W-1:0]  o_rdata,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push, w_pop;

    assign w_pop  = i_pop && (r_cnt != '0);
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + AW'(1);
            if (w_pop)  r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_wdata;
    end

    assign o_rdata = (r_cnt == '0) ? '0 : r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

endmodule

// File: rtl/spmv_row_pe.sv
// Streaming sparse matrix-vector row PE: y = A*x from a (val, col, eor) stream.
// Define SPMV_SAT_EN for saturating accumulation (default build wraps).
module spmv_row_pe
    import spmv_pkg::*;
#(
    parameter int VAL_W     = 16,
    parameter int IDX_W     = 8,
    parameter int ACC_W     = 32,
    parameter int ROW_W     = 16,
    parameter int OUT_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vec_wr_en,
    input  logic [IDX_W-1:0] vec_wr_addr,
    input  logic [VAL_W-1:0] vec_wr_data,
    input  logic             start,
    input  logic             nnz_valid,
    output logic             nnz_ready,
    input  logic [VAL_W-1:0] nnz_val,
    input  logic [IDX_W-1:0] nnz_col,
    input  logic             nnz_eor,
    input  logic             nnz_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic [ROW_W-1:0] res_row,
    output logic             busy,
    output logic             done
);
    localparam int VEC_DEPTH = 2 ** IDX_W;
    localparam int CW        = $clog2(OUT_DEPTH + 1);
    localparam int LS        = PIPE_DEPTH - 1;

    state_t                    r_state, w_state_nxt;
    logic [VAL_W-1:0]          r_vec [VEC_DEPTH];
    logic signed [VAL_W-1:0]   r_x, r_s1_val;
    logic [LS:1]               r_vld_pipe, r_eor_pipe;
    logic signed [2*VAL_W-1:0] r_prod;
    logic signed [ACC_W-1:0]   r_acc, w_prod_ext, w_sum;
    logic [ROW_W-1:0]          r_row;
    logic [CW-1:0]             w_cnt;
    logic                      w_empty, w_acc, w_push;
    logic [ACC_W+ROW_W-1:0]    w_head;

    // Three free slots cover every beat that can still be in flight.
    assign nnz_ready = (r_state == ST_RUN) && (w_cnt <= CW'(OUT_DEPTH - 3));
    assign w_acc     = nnz_valid && nnz_ready;

    always_ff @(posedge clk) begin
        if (vec_wr_en && r_state == ST_IDLE) r_vec[vec_wr_addr] <= vec_wr_data;
        if (w_acc) r_x <= r_vec[nnz_col];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            r_eor_pipe <= '0;
            r_s1_val   <= '0;
            r_prod     <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[LS-1:1], w_acc};
            r_eor_pipe <= {r_eor_pipe[LS-1:1], w_acc && (nnz_eor || nnz_last)};
            if (w_acc) r_s1_val <= nnz_val;
            r_prod     <= r_s1_val * r_x;
        end
    end

    assign w_prod_ext = ACC_W'(r_prod);
`ifdef SPMV_SAT_EN
    assign w_sum = ACC_W'(sat_add(64'(r_acc), 64'(w_prod_ext), ACC_W));
`else
    assign w_sum = r_acc + w_prod_ext;
`endif

    assign w_push = r_vld_pipe[LS] && r_eor_pipe[LS];

    // On eor the finished sum goes straight to the FIFO, so the next row starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_row <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_acc <= '0;
            r_row <= '0;
        end else if (r_vld_pipe[LS]) begin
            if (r_eor_pipe[LS]) begin
                r_acc <= '0;
                r_row <= r_row + ROW_W'(1);
            end else begin
                r_acc <= w_sum;
            end
        end
    end

    spmv_res_fifo #(.W(ACC_W + ROW_W), .DEPTH(OUT_DEPTH), .CW(CW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_wdata ({r_row, w_sum}),
        .i_pop   (res_ready),
        .o_rdata (w_head),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    assign res_valid = !w_empty;
    assign res_data  = w_head[ACC_W-1:0];
    assign res_row   = w_head[ACC_W+ROW_W-1:ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_acc && nnz_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (r_vld_pipe == '0 && w_empty) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_spmv_row_pe.sv
// Directed bench for spmv_row_pe: frame results, latency, backpressure,
// saturation/wrap, ignored controls during RUN, and mid-frame reset.
module tb_spmv_row_pe;
    localparam int VAL_W = 16, IDX_W = 8, ACC_W = 32, ROW_W = 16, OUT_DEPTH = 4;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             vec_wr_en = 1'b0;
    logic [IDX_W-1:0] vec_wr_addr = '0;
    logic [VAL_W-1:0] vec_wr_data = '0;
    logic             start = 1'b0, nnz_valid = 1'b0, nnz_eor = 1'b0, nnz_last = 1'b0;
    logic             nnz_ready, res_valid, busy, done;
    logic [VAL_W-1:0] nnz_val = '0;
    logic [IDX_W-1:0] nnz_col = '0;
    logic             res_ready = 1'b0;
    logic [ACC_W-1:0] res_data;
    logic [ROW_W-1:0] res_row;

    int n_cmp = 0, n_err = 0, n_acc = 0, n_done = 0;
    logic [ACC_W-1:0] q_data[$];
    logic [ROW_W-1:0] q_row[$];

    spmv_row_pe #(.VAL_W(VAL_W), .IDX_W(IDX_W), .ACC_W(ACC_W), .ROW_W(ROW_W),
                  .OUT_DEPTH(OUT_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .vec_wr_en(vec_wr_en), .vec_wr_addr(vec_wr_addr),
        .vec_wr_data(vec_wr_data), .start(start), .nnz_valid(nnz_valid),
        .nnz_ready(nnz_ready), .nnz_val(nnz_val), .nnz_col(nnz_col), .nnz_eor(nnz_eor),
        .nnz_last(nnz_last), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_row(res_row), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Record every result handed over and every done pulse.
    always @(negedge clk) begin
        #1;
        if (rst_n && res_valid && res_ready) begin
            q_data.push_back(res_data);
            q_row.push_back(res_row);
        end
        if (done) n_done++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic load_vec(input logic [IDX_W-1:0] a, input logic [VAL_W-1:0] d);
        vec_wr_en = 1'b1; vec_wr_addr = a; vec_wr_data = d;
        @(negedge clk);
        vec_wr_en = 1'b0;
    endtask

    task automatic load_x1234();
        load_vec(8'd0, 16'd1); load_vec(8'd1, 16'd2);
        load_vec(8'd2, 16'd3); load_vec(8'd3, 16'd4);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one beat and returns at the negedge after it was accepted (valid left high).
    task automatic send_beat(input logic [VAL_W-1:0] v, input logic [IDX_W-1:0] c,
                             input logic e, input logic l);
        int t = 0;
        nnz_valid = 1'b1; nnz_val = v; nnz_col = c; nnz_eor = e; nnz_last = l;
        while (!nnz_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!nnz_ready) begin
            n_cmp++; n_err++;
            $display("FAIL beat_accept_timeout: nnz_ready stayed 0 for %0d cycles", t);
            nnz_valid = 1'b0;
        end else begin
            @(negedge clk);
            n_acc++;
        end
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy && t < 500) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL %s_idle_timeout: busy=%0b after %0d cycles, need 0", name, busy, t);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        n_cmp++; if (nnz_ready !== 1'b0) begin n_err++; $display("FAIL reset_nnz_ready: got %0b need 0", nnz_ready); end
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %0b need 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b need 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b need 0", done); end
        n_cmp++; if (res_data !== 32'd0) begin n_err++; $display("FAIL reset_res_data: got %0h need 0", res_data); end
        n_cmp++; if (res_row !== 16'd0) begin n_err++; $display("FAIL reset_res_row: got %0h need 0", res_row); end
    endtask

    task automatic test_frame();
        logic [ACC_W-1:0] exp_d [4] = '{32'd5, 32'hFFFF_FFFE, 32'd0, 32'd10};
        int d0 = n_done;
        load_x1234();
        q_data.delete(); q_row.delete();
        res_ready = 1'b1;
        pulse_start();
        send_beat(16'd2, 8'd0, 1'b0, 1'b0);
        send_beat(16'd1, 8'd2, 1'b1, 1'b0);
        send_beat(16'hFFFF, 8'd1, 1'b1, 1'b0);
        send_beat(16'd0, 8'd0, 1'b1, 1'b0);
        send_beat(16'd1, 8'd0, 1'b0, 1'b0);
        send_beat(16'd1, 8'd1, 1'b0, 1'b0);
        send_beat(16'd1, 8'd2, 1'b0, 1'b0);
        send_beat(16'd1, 8'd3, 1'b1, 1'b1);
        nnz_valid = 1'b0;
        wait_idle("frame");
        n_cmp++; if (q_data.size() != 4) begin n_err++; $display("FAIL frame_count: got %0d results need 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            n_cmp++; if (q_data[i] !== exp_d[i]) begin n_err++; $display("FAIL frame_data[%0d]: got %0h need %0h", i, q_data[i], exp_d[i]); end
            n_cmp++; if (q_row[i] !== 16'(i)) begin n_err++; $display("FAIL frame_row[%0d]: got %0d need %0d", i, q_row[i], i); end
        end
        n_cmp++; if (n_done - d0 != 1) begin n_err++; $display("FAIL frame_done_pulses: got %0d need 1", n_done - d0); end
    endtask

    task automatic test_latency();
        int lat = 1;
        q_data.delete(); q_row.delete();
        res_ready = 1'b1;
        pulse_start();
        send_beat(16'd3, 8'd1, 1'b1, 1'b1);
        nnz_valid = 1'b0;
        while (!res_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++; if (lat != 3) begin n_err++; $display("FAIL latency: res_valid after %0d cycles need 3", lat); end
        wait_idle("latency");
        n_cmp++; if (q_data.size() != 1 || q_data[0] !== 32'd6 || q_row[0] !== 16'd0) begin
            n_err++; $display("FAIL latency_result: got %0d entries first %0h need one entry 6 row 0", q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'hx);
        end
    endtask

    task automatic test_backpressure();
        q_data.delete(); q_row.delete();
        res_ready = 1'b0;
        n_acc = 0;
        pulse_start();
        fork
            begin
                for (int k = 0; k < 10; k++) send_beat(16'(k + 1), 8'd0, 1'b1, k == 9);
                nnz_valid = 1'b0;
            end
            begin
                repeat (20) @(negedge clk);
                n_cmp++; if (nnz_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_low: got %0b need 0", nnz_ready); end
                n_cmp++; if (n_acc != 4) begin n_err++; $display("FAIL bp_accepted: got %0d beats need 4", n_acc); end
                n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL bp_res_valid: got %0b need 1", res_valid); end
                res_ready = 1'b1;
            end
        join
        wait_idle("backpressure");
        n_cmp++; if (q_data.size() != 10) begin n_err++; $display("FAIL bp_count: got %0d results need 10", q_data.size()); end
        for (int i = 0; i < 10 && i < q_data.size(); i++) begin
            n_cmp++; if (q_data[i] !== 32'(i + 1) || q_row[i] !== 16'(i)) begin
                n_err++; $display("FAIL bp_entry[%0d]: got %0h row %0d need %0h row %0d", i, q_data[i], q_row[i], i + 1, i);
            end
        end
    endtask

    task automatic test_saturation();
        logic [ACC_W-1:0] exp_v;
`ifdef SPMV_SAT_EN
        exp_v = 32'h7FFF_FFFF;
`else
        exp_v = 32'hBFFD_0003;
`endif
        load_vec(8'd0, 16'h7FFF);
        q_data.delete(); q_row.delete();
        res_ready = 1'b1;
        pulse_start();
        send_beat(16'h7FFF, 8'd0, 1'b0, 1'b0);
        send_beat(16'h7FFF, 8'd0, 1'b0, 1'b0);
        send_beat(16'h7FFF, 8'd0, 1'b1, 1'b1);
        nnz_valid = 1'b0;
        wait_idle("sat");
        n_cmp++; if (q_data.size() != 1 || q_data[0] !== exp_v) begin
            n_err++; $display("FAIL sat_result: got %0d entries first %0h need %0h", q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'hx, exp_v);
        end
    endtask

    task automatic test_ignore_in_run();
        load_x1234();
        q_data.delete(); q_row.delete();
        res_ready = 1'b1;
        pulse_start();
        send_beat(16'd1, 8'd1, 1'b0, 1'b0);
        nnz_valid = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; vec_wr_en = 1'b1; vec_wr_addr = 8'd1; vec_wr_data = 16'd99;
        @(negedge clk);
        start = 1'b0; vec_wr_en = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ign_busy: got %0b need 1", busy); end
        send_beat(16'd1, 8'd1, 1'b1, 1'b1);
        nnz_valid = 1'b0;
        wait_idle("ignore");
        pulse_start();
        send_beat(16'd1, 8'd1, 1'b1, 1'b1);
        nnz_valid = 1'b0;
        wait_idle("ignore2");
        n_cmp++; if (q_data.size() != 2) begin n_err++; $display("FAIL ign_count: got %0d results need 2", q_data.size()); end
        if (q_data.size() == 2) begin
            n_cmp++; if (q_data[0] !== 32'd4 || q_row[0] !== 16'd0) begin n_err++; $display("FAIL ign_start: got %0h row %0d need 4 row 0", q_data[0], q_row[0]); end
            n_cmp++; if (q_data[1] !== 32'd2 || q_row[1] !== 16'd0) begin n_err++; $display("FAIL ign_vec_write: got %0h row %0d need 2 row 0", q_data[1], q_row[1]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0 = n_done;
        res_ready = 1'b0;
        pulse_start();
        send_beat(16'd1, 8'd0, 1'b1, 1'b0);
        send_beat(16'd1, 8'd1, 1'b0, 1'b0);
        nnz_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (res_valid !== 1'b1) begin n_err++; $display("FAIL rst_pre_valid: got %0b need 1", res_valid); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %0b need 0", res_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b need 0", busy); end
        n_cmp++; if (nnz_ready !== 1'b0) begin n_err++; $display("FAIL rst_nnz_ready: got %0b need 0", nnz_ready); end
        n_cmp++; if (res_data !== 32'd0 || res_row !== 16'd0) begin n_err++; $display("FAIL rst_res: got %0h row %0d need 0 row 0", res_data, res_row); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        load_x1234();
        q_data.delete(); q_row.delete();
        res_ready = 1'b1;
        pulse_start();
        send_beat(16'd5, 8'd2, 1'b1, 1'b1);
        nnz_valid = 1'b0;
        wait_idle("rst");
        n_cmp++; if (q_data.size() != 1 || q_data[0] !== 32'd15 || q_row[0] !== 16'd0) begin
            n_err++; $display("FAIL rst_fresh_frame: got %0d entries first %0h need one entry 15 row 0", q_data.size(), (q_data.size() > 0) ? q_data[0] : 32'hx);
        end
        n_cmp++; if (n_done - d0 != 1) begin n_err++; $display("FAIL rst_done_pulses: got %0d need 1", n_done - d0); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_frame();
        test_latency();
        test_backpressure();
        test_saturation();
        test_ignore_in_run();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
